// File: rtl/sc_pkg.sv
// sc_pkg: shared definitions for the stochastic-computing window sequencer.
// Holds the default probability/counter widths, the sequencer state
// encoding and the window-exponent legality check used at start.
package sc_pkg;

  localparam int SC_DATA_W  = 9;
  localparam int SC_CNT_W   = 17;
  localparam int WIN_LOG2_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_LATCH = 3'd3,
    ST_SHIFT = 3'd4
  } sc_state_t;

  // The window must be at least one full probability word long and must
  // fit the up-counter.
  function automatic logic win_legal(input logic [WIN_LOG2_W-1:0] w,
                                     input int data_w, input int cnt_w);
    return (int'(w) >= data_w) && (int'(w) <= cnt_w);
  endfunction

endpackage

// File: rtl/sc_result_scaler.sv
// sc_result_scaler: maps a ones-count taken over a 2^W window back to a
// DATA_W-bit probability by dropping W-DATA_W LSBs. A count of 2^W (or
// more) cannot be represented and saturates to all ones.
//   count_in  : accumulated ones-count, CNT_W+1 bits
//   win_log2  : window exponent W (assumed DATA_W..CNT_W)
//   result    : scaled probability, DATA_W bits
module sc_result_scaler
  import sc_pkg::*;
#(
  parameter int DATA_W = SC_DATA_W,
  parameter int CNT_W  = SC_CNT_W
) (
  input  logic [CNT_W:0]          count_in,
  input  logic [WIN_LOG2_W-1:0]   win_log2,
  output logic [DATA_W-1:0]       result
);

  logic [CNT_W:0]        full_scale;
  logic [WIN_LOG2_W-1:0] shamt;
  logic                  sat;

  always_comb begin
    full_scale = {{CNT_W{1'b0}}, 1'b1} << win_log2;
    shamt      = win_log2 - WIN_LOG2_W'(DATA_W);
    sat        = (count_in >= full_scale);
    result     = sat ? '1 : DATA_W'(count_in >> shamt);
  end

endmodule

// File: rtl/sc_window_sequencer.sv
// sc_window_sequencer: sequences one stochastic-computing evaluation with a
// start/busy/done handshake: serial operand load, accumulator clear, a
// 2^W-cycle accumulation window, result scaling and serial result output.
//   clk, rst_n        : clock, async active-low reset
//   start, cont       : begin evaluation (IDLE only); loop back to LOAD
//   win_log2          : window exponent W, legal DATA_W..CNT_W
//   ser_a, ser_b      : serial operands, LSB first
//   op_a, op_b        : loaded operand words to SN generators
//   acc_clr, acc_en   : datapath up-counter clear / enable
//   count_in          : accumulated ones-count
//   result, result_valid : scaled result and its update pulse
//   ser_out, frame_out   : serial result, LSB first, and its frame
//   busy, cfg_err     : not IDLE; pulse on start with illegal W
//
// state | meaning
// IDLE  | waiting for start, W sampled here
// LOAD  | shifting in DATA_W operand bits, acc_clr on last bit
// RUN   | accumulation window, acc_en for 2^W cycles
// LATCH | capture scaled count_in
// SHIFT | shifting result out, frame_out high
module sc_window_sequencer
  import sc_pkg::*;
#(
  parameter int DATA_W = SC_DATA_W,
  parameter int CNT_W  = SC_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cont,
  input  logic [WIN_LOG2_W-1:0] win_log2,
  input  logic                  ser_a,
  input  logic                  ser_b,
  output logic [DATA_W-1:0]     op_a,
  output logic [DATA_W-1:0]     op_b,
  output logic                  acc_clr,
  output logic                  acc_en,
  input  logic [CNT_W:0]        count_in,
  output logic [DATA_W-1:0]     result,
  output logic                  result_valid,
  output logic                  ser_out,
  output logic                  frame_out,
  output logic                  busy,
  output logic                  cfg_err
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W:0]   WIN_ONE  = {{CNT_W{1'b0}}, 1'b1};

  sc_state_t             state, state_nxt;
  logic [WIN_LOG2_W-1:0] w_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic [CNT_W:0]        win_cnt;
  logic [DATA_W-1:0]     sh_a, sh_b, res_sh;
  logic [DATA_W-1:0]     scaled;
  logic                  start_ok;

  assign start_ok = start && win_legal(win_log2, DATA_W, CNT_W);

  sc_result_scaler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_scaler (
    .count_in (count_in),
    .win_log2 (w_q),
    .result   (scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    frame_out = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (bit_cnt == LAST_BIT) begin
          acc_clr   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_en = 1'b1;
        if (win_cnt == '0) state_nxt = ST_LATCH;
      end
      ST_LATCH: state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        frame_out = 1'b1;
        if (bit_cnt == LAST_BIT) state_nxt = cont ? ST_LOAD : ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ser_out = frame_out & res_sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q          <= '0;
      bit_cnt      <= '0;
      win_cnt      <= '0;
      sh_a         <= '0;
      sh_b         <= '0;
      res_sh       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err      <= (state == ST_IDLE) && start && !start_ok;
      result_valid <= (state == ST_LATCH);
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            w_q     <= win_log2;
            bit_cnt <= '0;
          end
        end
        ST_LOAD: begin
          sh_a    <= {ser_a, sh_a[DATA_W-1:1]};
          sh_b    <= {ser_b, sh_b[DATA_W-1:1]};
          bit_cnt <= bit_cnt + BIT_ONE;
          if (bit_cnt == LAST_BIT) begin
            op_a    <= {ser_a, sh_a[DATA_W-1:1]};
            op_b    <= {ser_b, sh_b[DATA_W-1:1]};
            win_cnt <= (WIN_ONE << w_q) - WIN_ONE;
            bit_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (win_cnt != '0) win_cnt <= win_cnt - WIN_ONE;
        end
        ST_LATCH: begin
          result  <= scaled;
          res_sh  <= scaled;
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          res_sh  <= res_sh >> 1;
          bit_cnt <= bit_cnt + BIT_ONE;
          if (bit_cnt == LAST_BIT) bit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_window_sequencer.sv
// tb_sc_window_sequencer: directed bench for sc_window_sequencer.
module tb_sc_window_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic [4:0]  win_log2;
  logic        ser_a;
  logic        ser_b;
  logic [8:0]  op_a;
  logic [8:0]  op_b;
  logic        acc_clr;
  logic        acc_en;
  logic [17:0] count_in;
  logic [8:0]  result;
  logic        result_valid;
  logic        ser_out;
  logic        frame_out;
  logic        busy;
  logic        cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0, n_en = 0, n_busy = 0, n_clr = 0, n_cfg = 0;
  int rv_n = 0, rv_last = 0, rv_prev = 0;

  sc_window_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cont         (cont),
    .win_log2     (win_log2),
    .ser_a        (ser_a),
    .ser_b        (ser_b),
    .op_a         (op_a),
    .op_b         (op_b),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .count_in     (count_in),
    .result       (result),
    .result_valid (result_valid),
    .ser_out      (ser_out),
    .frame_out    (frame_out),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (acc_en)  n_en++;
    if (busy)    n_busy++;
    if (acc_clr) n_clr++;
    if (cfg_err) n_cfg++;
    if (result_valid) begin
      rv_n++;
      rv_prev = rv_last;
      rv_last = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_eval(input string tag, input logic [4:0] w, input logic [8:0] a,
                          input logic [8:0] b, input logic [17:0] cnt,
                          input logic [8:0] exp_res, input bit retrig);
    int en0, busy0, clr0, n;
    bit seen;
    en0 = n_en; busy0 = n_busy; clr0 = n_clr;
    count_in = cnt; win_log2 = w; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      ser_a = a[k];
      ser_b = b[k];
      tick();
    end
    chk({tag, "_op_a"}, 32'(op_a), 32'(a));
    chk({tag, "_op_b"}, 32'(op_b), 32'(b));
    chk({tag, "_acc_clr_cnt"}, n_clr - clr0, 1);
    n = 10;
    seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (frame_out) begin
        seen = 1'b1;
        break;
      end
      if (retrig && i >= 100 && i < 103) begin
        start = 1'b1; win_log2 = 5'd12;
      end else begin
        start = 1'b0; win_log2 = w;
      end
      tick();
      n++;
    end
    start = 1'b0;
    win_log2 = w;
    chk({tag, "_frame_seen"}, 32'(seen), 1);
    chk({tag, "_latency"}, n, 9 + (1 << w) + 2);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_result_valid"}, 32'(result_valid), 1);
    for (int k = 0; k < 9; k++) begin
      chk({tag, "_ser_bit"}, {30'd0, frame_out, ser_out}, {30'd0, 1'b1, exp_res[k]});
      tick();
    end
    chk({tag, "_end_frame"}, {29'd0, frame_out, ser_out, busy}, 32'd0);
    chk({tag, "_acc_en_cnt"}, n_en - en0, 1 << w);
    chk({tag, "_busy_cnt"}, n_busy - busy0, 2 * 9 + (1 << w) + 1);
  endtask

  initial begin
    int en0, busy0, clr0, rv0, cfg0, drops;
    bit got;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; win_log2 = 5'd9;
    ser_a = 1'b0; ser_b = 1'b0; count_in = '0;
    repeat (3) tick();
    chk("rst_ops", {14'd0, op_a, op_b}, 32'd0);
    chk("rst_result", {22'd0, result, result_valid}, 32'd0);
    chk("rst_ctrl", {26'd0, acc_clr, acc_en, ser_out, frame_out, busy, cfg_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic W=9 evaluation, 300 -> 0x12C
    run_eval("w9", 5'd9, 9'h0AB, 9'h155, 18'd300, 9'h12C, 1'b0);
    tick();
    chk("w9_rv_drop", 32'(result_valid), 0);

    // W=12 scaling and saturation
    run_eval("w12", 5'd12, 9'h1C3, 9'h03C, 18'd2048, 9'd256, 1'b0);
    run_eval("w12sat", 5'd12, 9'h001, 9'h100, 18'd4096, 9'h1FF, 1'b0);

    // start during RUN is ignored
    run_eval("retrig", 5'd9, 9'h0F0, 9'h00F, 18'd100, 9'd100, 1'b1);

    // illegal window exponents
    en0 = n_en; busy0 = n_busy; cfg0 = n_cfg;
    win_log2 = 5'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg5_err", {30'd0, cfg_err, busy}, 32'b10);
    tick();
    chk("cfg5_pulse", 32'(cfg_err), 0);
    win_log2 = 5'd18; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg18_err", {30'd0, cfg_err, busy}, 32'b10);
    repeat (5) tick();
    chk("cfg_err_cnt", n_cfg - cfg0, 2);
    chk("cfg_no_busy", n_busy - busy0, 0);
    chk("cfg_no_en", n_en - en0, 0);

    // continuous mode, two frames
    busy0 = n_busy; clr0 = n_clr; rv0 = rv_n;
    cont = 1'b1; win_log2 = 5'd9; count_in = 18'd300; start = 1'b1;
    tick();
    start = 1'b0;
    drops = 0;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rv_n - rv0 >= 2) begin
        got = 1'b1;
        break;
      end
      if (!busy) drops++;
      tick();
    end
    cont = 1'b0;
    chk("cont_two_rv", 32'(got), 1);
    chk("cont_busy_drops", drops, 0);
    chk("cont_rv_spacing", rv_last - rv_prev, 531);
    chk("cont_result", 32'(result), 32'h12C);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("cont_stop", 32'(got), 1);
    chk("cont_acc_clr_cnt", n_clr - clr0, 2);
    chk("cont_busy_cnt", n_busy - busy0, 2 * 531);

    // asynchronous abort in RUN
    win_log2 = 5'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      ser_a = 1'b1; ser_b = 1'b0;
      tick();
    end
    repeat (100) tick();
    chk("abort_pre_en", {31'd0, acc_en}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {27'd0, acc_clr, acc_en, ser_out, frame_out, busy}, 32'd0);
    chk("abort_data", {13'd0, op_a, result, result_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en0 = n_en; busy0 = n_busy;
    repeat (20) tick();
    chk("abort_idle_busy", n_busy - busy0, 0);
    chk("abort_idle_en", n_en - en0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
